// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream writer for the instruction memory write port.
//                Receives a 4-byte little-endian word count followed by the
//                payload words. Each payload word is written starting at
//                BASE_WORD. The core is held in reset while a load runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int BASE_WORD  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_BYTES-1:0] wen_o,
  output logic                  core_rst_n_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Largest load that still fits between BASE_WORD and the top of memory;
  // keeping N at or below this is what guarantees addresses never wrap.
  localparam logic [31:0]           MAX_WORDS = 32'(DEPTH - BASE_WORD);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_WORD);
  localparam logic [1:0]            LAST_IDX  = 2'(DATA_BYTES - 1);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic [31:0] n_words;

  logic [31:0] next_word;
  logic        xfer;
  logic        last_word;

  // Little-endian assembly: each new byte enters at the top, so after four
  // bytes the first one received sits in bits [7:0].
  assign next_word = {byte_i, shreg[31:8]};
  assign xfer      = byte_valid_i & byte_ready_o;
  // word_cnt_o equals the index k of the word being completed.
  assign last_word = (32'(word_cnt_o) == (n_words - 32'd1));

  // Load sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      shreg        <= '0;
      n_words      <= '0;
      byte_ready_o <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      wen_o        <= '0;
      core_rst_n_o <= 1'b1;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      wen_o <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state        <= S_LEN;
            byte_idx     <= 2'd0;
            byte_ready_o <= 1'b1;
            core_rst_n_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_cnt_o   <= '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            shreg    <= next_word;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              n_words <= next_word;
              if (next_word == 32'd0) begin
                state        <= S_DONE;
                byte_ready_o <= 1'b0;
                core_rst_n_o <= 1'b1;
                done_o       <= 1'b1;
              end else if (next_word > MAX_WORDS) begin
                // Core stays held in reset after a rejected load.
                state        <= S_ERR;
                byte_ready_o <= 1'b0;
                err_o        <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            shreg    <= next_word;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == LAST_IDX) begin
              wen_o      <= '1;
              waddr_o    <= BASE_ADDR + word_cnt_o[ADDR_WIDTH-1:0];
              wdata_o    <= DATA_WIDTH'(next_word);
              word_cnt_o <= word_cnt_o + 1'b1;
              if (last_word) begin
                state        <= S_FLUSH;
                byte_ready_o <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: begin
          // The final strobe is on the port during this cycle; the core is
          // released only after it, so its first fetch sees the new code.
          state        <= S_DONE;
          core_rst_n_o <= 1'b1;
          done_o       <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic [DB-1:0] wen_o;
  logic          core_rst_n_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   word_cnt_o;

  imem_loader #(
    .ADDR_WIDTH(AW), .DEPTH(1024), .DATA_WIDTH(DW), .DATA_BYTES(DB), .BASE_WORD(64)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .wen_o(wen_o),
    .core_rst_n_o(core_rst_n_o), .done_o(done_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Write strobe log, filled whenever any byte enable is seen high.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] wr_en_q[$];
  int          wr_cyc_q[$];

  always @(negedge clk) begin
    if (wen_o != '0) begin
      wr_addr_q.push_back(32'(waddr_o));
      wr_data_q.push_back(32'(wdata_o));
      wr_en_q.push_back(32'(wen_o));
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_en_q.delete();
    wr_cyc_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where the loader sits in LEN.
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(byte_ready_o), 64'd1);
    byte_valid_i = 1'b1;
    byte_i       = b;
    @(posedge clk);
    @(negedge clk);
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit last);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (last && i == 3) ? 0 : gap);
  endtask

  // Normal two-word program; gap idles follow every byte except the last.
  task automatic normal_load(input string t, input int gap);
    clear_log();
    pulse_start();
    check({t, "_start_ready"}, 64'(byte_ready_o), 64'd1);
    check({t, "_start_core_rst"}, 64'(core_rst_n_o), 64'd0);
    send_word(32'd2, gap, 1'b0);
    send_word(32'h0000_0013, gap, 1'b0);
    send_word(32'h0010_0093, gap, 1'b1);
    check({t, "_flush_wen"}, 64'(wen_o), 64'hF);
    check({t, "_flush_addr"}, 64'(waddr_o), 64'd65);
    check({t, "_flush_data"}, 64'(wdata_o), 64'h0010_0093);
    check({t, "_flush_done"}, 64'(done_o), 64'd0);
    check({t, "_flush_core_rst"}, 64'(core_rst_n_o), 64'd0);
    @(negedge clk);
    check({t, "_done"}, 64'(done_o), 64'd1);
    check({t, "_core_rst"}, 64'(core_rst_n_o), 64'd1);
    check({t, "_ready"}, 64'(byte_ready_o), 64'd0);
    check({t, "_wen_off"}, 64'(wen_o), 64'd0);
    check({t, "_cnt"}, 64'(word_cnt_o), 64'd2);
    check({t, "_nwr"}, 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check({t, "_wr0_addr"}, 64'(wr_addr_q[0]), 64'd64);
      check({t, "_wr0_data"}, 64'(wr_data_q[0]), 64'h13);
      check({t, "_wr0_en"}, 64'(wr_en_q[0]), 64'hF);
      check({t, "_wr1_addr"}, 64'(wr_addr_q[1]), 64'd65);
      check({t, "_wr1_data"}, 64'(wr_data_q[1]), 64'h0010_0093);
      check({t, "_spacing"}, 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'(gap > 0 ? 8 : 4));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    // ---------------- reset state ----------------
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(byte_ready_o), 64'd0);
    check("rst_wen", 64'(wen_o), 64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    check("rst_wdata", 64'(wdata_o), 64'd0);
    check("rst_core_rst", 64'(core_rst_n_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_cnt", 64'(word_cnt_o), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(byte_ready_o), 64'd0);
    check("idle_core_rst", 64'(core_rst_n_o), 64'd1);

    // ---------------- normal back-to-back load ----------------
    normal_load("t1", 0);

    // ---------------- zero length ----------------
    clear_log();
    pulse_start();
    check("t2_start_done_clr", 64'(done_o), 64'd0);
    check("t2_start_cnt_clr", 64'(word_cnt_o), 64'd0);
    send_word(32'd0, 0, 1'b1);
    check("t2_done", 64'(done_o), 64'd1);
    check("t2_core_rst", 64'(core_rst_n_o), 64'd1);
    check("t2_ready", 64'(byte_ready_o), 64'd0);
    check("t2_cnt", 64'(word_cnt_o), 64'd0);
    check("t2_nwr", 64'(wr_addr_q.size()), 64'd0);

    // ---------------- oversize, then huge N, then recovery ----------------
    clear_log();
    pulse_start();
    send_word(32'd961, 0, 1'b1);
    check("t3_err", 64'(err_o), 64'd1);
    check("t3_done", 64'(done_o), 64'd0);
    check("t3_core_rst", 64'(core_rst_n_o), 64'd0);
    check("t3_ready", 64'(byte_ready_o), 64'd0);
    repeat (3) @(negedge clk);
    check("t3_err_hold", 64'(err_o), 64'd1);
    check("t3_core_hold", 64'(core_rst_n_o), 64'd0);
    pulse_start();
    check("t3_err_clr", 64'(err_o), 64'd0);
    send_word(32'h0100_0000, 0, 1'b1);
    check("t3_err_wide", 64'(err_o), 64'd1);
    check("t3_nwr", 64'(wr_addr_q.size()), 64'd0);
    pulse_start();
    send_word(32'd1, 0, 1'b0);
    send_word(32'h1234_5678, 0, 1'b1);
    check("t3_rec_wen", 64'(wen_o), 64'hF);
    check("t3_rec_addr", 64'(waddr_o), 64'd64);
    check("t3_rec_data", 64'(wdata_o), 64'h1234_5678);
    @(negedge clk);
    check("t3_rec_done", 64'(done_o), 64'd1);
    check("t3_rec_err", 64'(err_o), 64'd0);
    check("t3_rec_cnt", 64'(word_cnt_o), 64'd1);
    check("t3_rec_nwr", 64'(wr_addr_q.size()), 64'd1);

    // ---------------- largest legal load, N = 960 ----------------
    clear_log();
    pulse_start();
    send_word(32'd960, 0, 1'b0);
    check("t4_not_err", 64'(err_o), 64'd0);
    for (int k = 0; k < 960; k++)
      send_word(32'hA500_0000 | 32'(k), 0, k == 959);
    @(negedge clk);
    check("t4_done", 64'(done_o), 64'd1);
    check("t4_cnt", 64'(word_cnt_o), 64'd960);
    check("t4_nwr", 64'(wr_addr_q.size()), 64'd960);
    bad = 0;
    if (wr_addr_q.size() == 960) begin
      for (int k = 0; k < 960; k++)
        if (wr_addr_q[k] != 32'(64 + k) || wr_data_q[k] != (32'hA500_0000 | 32'(k)))
          bad++;
      check("t4_last_addr", 64'(wr_addr_q[959]), 64'd1023);
    end
    check("t4_content_bad", 64'(bad), 64'd0);

    // ---------------- gapped stream ----------------
    normal_load("t5", 1);

    // ---------------- start pulsed mid-DATA ----------------
    clear_log();
    pulse_start();
    send_word(32'd2, 0, 1'b0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("t6_ready", 64'(byte_ready_o), 64'd1);
    check("t6_core_rst", 64'(core_rst_n_o), 64'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_word(32'h0010_0093, 0, 1'b1);
    @(negedge clk);
    check("t6_done", 64'(done_o), 64'd1);
    check("t6_cnt", 64'(word_cnt_o), 64'd2);
    check("t6_nwr", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check("t6_wr0_data", 64'(wr_data_q[0]), 64'h13);
      check("t6_wr1_addr", 64'(wr_addr_q[1]), 64'd65);
      check("t6_wr1_data", 64'(wr_data_q[1]), 64'h0010_0093);
    end

    // ---------------- async reset mid-load, then restart ----------------
    clear_log();
    pulse_start();
    send_word(32'd2, 0, 1'b0);
    send_word(32'h0000_0013, 0, 1'b0);
    send_byte(8'h93, 0);
    #1 rst = 1'b0;
    #1;
    check("t7_ready", 64'(byte_ready_o), 64'd0);
    check("t7_wen", 64'(wen_o), 64'd0);
    check("t7_waddr", 64'(waddr_o), 64'd0);
    check("t7_wdata", 64'(wdata_o), 64'd0);
    check("t7_core_rst", 64'(core_rst_n_o), 64'd1);
    check("t7_done", 64'(done_o), 64'd0);
    check("t7_err", 64'(err_o), 64'd0);
    check("t7_cnt", 64'(word_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_word(32'd1, 0, 1'b0);
    send_word(32'hCAFE_F00D, 0, 1'b1);
    check("t7_rec_wen", 64'(wen_o), 64'hF);
    check("t7_rec_addr", 64'(waddr_o), 64'd64);
    check("t7_rec_data", 64'(wdata_o), 64'hCAFE_F00D);
    @(negedge clk);
    check("t7_rec_done", 64'(done_o), 64'd1);
    check("t7_rec_cnt", 64'(word_cnt_o), 64'd1);
    check("t7_rec_nwr", 64'(wr_addr_q.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
